// File: rtl/store_commit_unit_if.sv
// Store-commit bus: retire lanes from the store queue, dcache write port,
// and the completion path back to the store queue.
// master = environment side (store queue + dcache), slave = commit unit side.
interface store_commit_unit_if #(
    parameter int N_WAY     = 2,
    parameter int N_SQ      = 8,
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 4
);
    localparam int PW = $clog2(N_SQ) + 1;
    localparam int FW = $clog2(BUF_DEPTH) + 1;

    logic [N_WAY-1:0]           ret_valid;
    logic [N_WAY-1:0][XLEN-1:0] ret_addr;
    logic [N_WAY-1:0][XLEN-1:0] ret_data;
    logic [N_WAY-1:0][1:0]      ret_size;
    logic [N_WAY-1:0][PW-1:0]   ret_pos;
    logic [FW-1:0]              buf_free;
    logic                       overflow_err;
    logic                       mem_req;
    logic [XLEN-1:0]            mem_addr;
    logic [XLEN-1:0]            mem_wdata;
    logic [3:0]                 mem_be;
    logic                       mem_gnt;
    logic                       mem_done;
    logic                       ack_valid;
    logic [PW-1:0]              ack_pos;
    logic                       misalign_err;

    modport master (
        output ret_valid, ret_addr, ret_data, ret_size, ret_pos, mem_gnt, mem_done,
        input  buf_free, overflow_err, mem_req, mem_addr, mem_wdata, mem_be,
               ack_valid, ack_pos, misalign_err
    );

    modport slave (
        input  ret_valid, ret_addr, ret_data, ret_size, ret_pos, mem_gnt, mem_done,
        output buf_free, overflow_err, mem_req, mem_addr, mem_wdata, mem_be,
               ack_valid, ack_pos, misalign_err
    );
endinterface

// File: rtl/store_commit_unit.sv
// Store commit unit: buffers retired stores in order (compacting valid lanes),
// writes the head entry to the dcache via req/gnt/done, and acks its SQ position.
// Optional macro MISALIGN_CHECK_EN: misaligned HALF/WORD stores are popped
// without a memory write, still acked, and flagged on sticky misalign_err.
module store_commit_unit #(
    parameter int N_WAY     = 2,
    parameter int N_SQ      = 8,
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 4
) (
    input logic                clock,
    input logic                reset,
    store_commit_unit_if.slave bus
);
    localparam int PW = $clog2(N_SQ) + 1;
    localparam int FW = $clog2(BUF_DEPTH) + 1;
    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   entry_addr [BUF_DEPTH];
    logic [XLEN-1:0]   entry_data [BUF_DEPTH];
    logic [1:0]        entry_size [BUF_DEPTH];
    logic [PW-1:0]     entry_pos  [BUF_DEPTH];
    logic [AW-1:0]     head_reg, tail_reg;
    logic [FW-1:0]     free_reg;
    logic              overflow_reg;
    logic              ack_valid_reg;
    logic [PW-1:0]     ack_pos_reg;

    logic [FW-1:0]     lane_cnt;
    logic [FW-1:0]     lane_offset [N_WAY];
    logic [AW-1:0]     lane_idx    [N_WAY];
    logic [N_WAY-1:0]  lane_accept;
    logic [FW-1:0]     push_count;
    logic              drop;
    logic              pop;
    logic              buf_empty;
    logic              remain;
    logic              head_bad;
    logic [FW-1:0]     occupancy;
    logic [XLEN-1:0]   head_addr, head_data;
    logic [1:0]        head_size;
    logic [3:0]        fmt_be;
    logic [XLEN-1:0]   fmt_wdata;
    logic              req_active;

`ifdef MISALIGN_CHECK_EN
    logic              entry_bad [BUF_DEPTH];
    logic [N_WAY-1:0]  lane_bad;
    logic              misalign_reg;
`endif

    assign buf_empty = (free_reg == FW'(BUF_DEPTH));
    assign occupancy = FW'(BUF_DEPTH) - free_reg;
    // After a pop, entries remain if the old content plus this cycle's pushes exceeds one.
    assign remain    = ((occupancy + push_count) > FW'(1));
    assign head_addr = entry_addr[head_reg];
    assign head_data = entry_data[head_reg];
    assign head_size = entry_size[head_reg];

    // Compact valid lanes: each gets the next slot past tail; lanes beyond free space drop.
    always_comb begin
        lane_cnt    = '0;
        push_count  = '0;
        drop        = 1'b0;
        lane_accept = '0;
        for (int i = 0; i < N_WAY; i++) begin
            lane_offset[i] = lane_cnt;
            lane_accept[i] = bus.ret_valid[i] && (lane_cnt < free_reg);
            if (bus.ret_valid[i]) lane_cnt = lane_cnt + FW'(1);
            if (lane_accept[i]) push_count = push_count + FW'(1);
            if (bus.ret_valid[i] && !lane_accept[i]) drop = 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_WAY; gi++) begin : g_lane
        assign lane_idx[gi] = AW'({1'b0, tail_reg} + lane_offset[gi]);
`ifdef MISALIGN_CHECK_EN
        assign lane_bad[gi] = ((bus.ret_size[gi] == 2'd1) && bus.ret_addr[gi][0]) ||
                              ((bus.ret_size[gi] == 2'd2) && (bus.ret_addr[gi][1:0] != 2'b00));
`endif
    end

`ifdef MISALIGN_CHECK_EN
    assign head_bad = !buf_empty && entry_bad[head_reg];
`else
    assign head_bad = 1'b0;
`endif

    // Buffer storage: write accepted lanes at their compacted slots.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_addr[i] <= '0;
                entry_data[i] <= '0;
                entry_size[i] <= '0;
                entry_pos[i]  <= '0;
`ifdef MISALIGN_CHECK_EN
                entry_bad[i]  <= 1'b0;
`endif
            end
        end else begin
            for (int i = 0; i < N_WAY; i++) begin
                if (lane_accept[i]) begin
                    entry_addr[lane_idx[i]] <= bus.ret_addr[i];
                    entry_data[lane_idx[i]] <= bus.ret_data[i];
                    entry_size[lane_idx[i]] <= bus.ret_size[i];
                    entry_pos[lane_idx[i]]  <= bus.ret_pos[i];
`ifdef MISALIGN_CHECK_EN
                    entry_bad[lane_idx[i]]  <= lane_bad[i];
`endif
                end
            end
        end
    end

    // Pointers, free count, sticky errors and the one-cycle ack pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            free_reg      <= FW'(BUF_DEPTH);
            overflow_reg  <= 1'b0;
            ack_valid_reg <= 1'b0;
            ack_pos_reg   <= '0;
`ifdef MISALIGN_CHECK_EN
            misalign_reg  <= 1'b0;
`endif
        end else begin
            tail_reg      <= AW'({1'b0, tail_reg} + push_count);
            if (pop) head_reg <= head_reg + AW'(1);
            free_reg      <= free_reg - push_count + FW'(pop);
            if (drop) overflow_reg <= 1'b1;
            ack_valid_reg <= pop;
            ack_pos_reg   <= pop ? entry_pos[head_reg] : '0;
`ifdef MISALIGN_CHECK_EN
            if (pop && head_bad) misalign_reg <= 1'b1;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM next state and pop decision; bad heads are discarded without a write.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (head_bad) begin
                    pop        = 1'b1;
                    state_next = remain ? REQ : IDLE;
                end else if (!buf_empty || (push_count != '0)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (head_bad) begin
                    pop        = 1'b1;
                    state_next = remain ? REQ : IDLE;
                end else if (bus.mem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_done) begin
                    pop        = 1'b1;
                    state_next = remain ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane placement of the head store within the 32-bit word.
    always_comb begin
        fmt_be    = 4'b1111;
        fmt_wdata = head_data;
        case (head_size)
            2'd0: begin
                fmt_be    = 4'b0001 << head_addr[1:0];
                fmt_wdata = XLEN'(head_data[7:0]) << {head_addr[1:0], 3'b000};
            end
            2'd1: begin
                fmt_be    = head_addr[1] ? 4'b1100 : 4'b0011;
                fmt_wdata = XLEN'(head_data[15:0]) << {head_addr[1], 4'b0000};
            end
            default: begin
                fmt_be    = 4'b1111;
                fmt_wdata = head_data;
            end
        endcase
    end

    assign req_active       = (state_reg == REQ) && !head_bad;
    assign bus.mem_req      = req_active;
    assign bus.mem_addr     = req_active ? {head_addr[XLEN-1:2], 2'b00} : '0;
    assign bus.mem_wdata    = req_active ? fmt_wdata : '0;
    assign bus.mem_be       = req_active ? fmt_be : 4'b0000;
    assign bus.buf_free     = free_reg;
    assign bus.overflow_err = overflow_reg;
    assign bus.ack_valid    = ack_valid_reg;
    assign bus.ack_pos      = ack_pos_reg;
`ifdef MISALIGN_CHECK_EN
    assign bus.misalign_err = misalign_reg;
`else
    assign bus.misalign_err = 1'b0;
`endif
endmodule
